// File: rtl/ti_stop_req_controller_pkg.sv
// ----------------------------------------------------------------------------
// ti_stop_req_controller_pkg
//   Shared types and helpers for the stop_req/stop_ack initiator.
//   - state_e     : controller FSM states
//   - timer_width : width of the wait-phase down-counter
// ----------------------------------------------------------------------------
package ti_stop_req_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQ        = 3'd1,
    ST_DECOUPLE   = 3'd2,
    ST_PAUSED     = 3'd3,
    ST_UNDECOUPLE = 3'd4,
    ST_RELEASE    = 3'd5
  } state_e;

  // Counter must hold the larger of the two wait lengths without wrapping.
  function automatic int timer_width(input int timeout_cycles, input int settle_cycles);
    int max_v;
    max_v = (timeout_cycles > settle_cycles) ? timeout_cycles : settle_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/ti_stop_req_controller_if.sv
// ----------------------------------------------------------------------------
// ti_stop_req_controller_if
//   Command/status and stop handshake bundle of the stop_req controller.
//   Ports (master = controller side):
//     pause_cmd, resume_cmd  : single-cycle command pulses from the register block
//     stop_req  [NUM_CH]     : stop request per channel, to the AXIS wrapper
//     stop_ack  [NUM_CH]     : stop acknowledge per channel (level), from the wrapper
//     decouple               : isolates DUT AXIS valid/ready/last from the system
//     paused, busy           : status
//     timeout_err            : sticky ack/release wait timeout
//     ack_snapshot [NUM_CH]  : stop_ack captured at the timeout cycle
// ----------------------------------------------------------------------------
interface ti_stop_req_controller_if #(
  parameter int NUM_CH = 2
);
  logic              pause_cmd;
  logic              resume_cmd;
  logic [NUM_CH-1:0] stop_req;
  logic [NUM_CH-1:0] stop_ack;
  logic              decouple;
  logic              paused;
  logic              busy;
  logic              timeout_err;
  logic [NUM_CH-1:0] ack_snapshot;

  modport master (
    input  pause_cmd, resume_cmd, stop_ack,
    output stop_req, decouple, paused, busy, timeout_err, ack_snapshot
  );

  modport slave (
    output pause_cmd, resume_cmd, stop_ack,
    input  stop_req, decouple, paused, busy, timeout_err, ack_snapshot
  );
endinterface

// File: rtl/ti_stop_req_controller_timer.sv
// ----------------------------------------------------------------------------
// ti_stop_req_controller_timer
//   Loadable down-counter shared by the ack wait and the settle wait.
//   Ports:
//     i_clk, i_rst_n : clock, async active-low reset
//     i_load         : load i_value on this edge
//     i_value        : wait length N
//     o_expired      : count reaches 0 on the coming edge; a wait loaded
//                      with N therefore ends exactly N edges after the load
// ----------------------------------------------------------------------------
module ti_stop_req_controller_timer #(
  parameter int W = 13
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count <= W'(1));

endmodule

// File: rtl/ti_stop_req_controller.sv
// ----------------------------------------------------------------------------
// ti_stop_req_controller
//   Initiator side of the stop_req/stop_ack protocol. A pause command stops
//   every channel, waits for all acks, then decouples and reports paused.
//   A resume command reverses the sequence.
//   Ports:
//     i_aclk    : clock
//     i_aresetn : async active-low reset
//     bus       : ti_stop_req_controller_if.master (commands, handshake, status)
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | running, nothing requested
//   REQ        | stop_req all-ones, waiting for all acks (timeout armed)
//   DECOUPLE   | decouple asserted, waiting for it to settle
//   PAUSED     | stopped and decoupled, waiting for resume
//   UNDECOUPLE | decouple released, waiting for it to settle
//   RELEASE    | stop_req dropped, waiting for all acks low (timeout armed)
// ----------------------------------------------------------------------------
module ti_stop_req_controller
  import ti_stop_req_controller_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int SETTLE_CYCLES    = 4,
  parameter int FORCE_ON_TIMEOUT = 0
) (
  input logic                       i_aclk,
  input logic                       i_aresetn,
  ti_stop_req_controller_if.master  bus
);

  localparam int              TW         = timer_width(TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0]   TIMEOUT_LD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   SETTLE_LD  = TW'(SETTLE_CYCLES);

  state_e            r_state;
  state_e            w_next;
  logic              w_timeout_evt;
  logic              w_expired;
  logic              w_ack_all;
  logic              w_ack_none;

  logic              w_load;
  logic [TW-1:0]     w_load_val;
  logic [NUM_CH-1:0] w_stop_req_nxt;
  logic              w_decouple_nxt;
  logic              w_paused_nxt;
  logic              w_busy_nxt;
  logic              w_timeout_err_nxt;
  logic [NUM_CH-1:0] w_ack_snapshot_nxt;

  logic [NUM_CH-1:0] r_stop_req;
  logic              r_decouple;
  logic              r_paused;
  logic              r_busy;
  logic              r_timeout_err;
  logic [NUM_CH-1:0] r_ack_snapshot;

  assign w_ack_all  = &bus.stop_ack;
  assign w_ack_none = ~|bus.stop_ack;

  ti_stop_req_controller_timer #(.W(TW)) u_timer (
    .i_clk     (i_aclk),
    .i_rst_n   (i_aresetn),
    .i_load    (w_load),
    .i_value   (w_load_val),
    .o_expired (w_expired)
  );

  // State and output registers
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state        <= ST_IDLE;
      r_stop_req     <= '0;
      r_decouple     <= 1'b0;
      r_paused       <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_ack_snapshot <= '0;
    end else begin
      r_state        <= w_next;
      r_stop_req     <= w_stop_req_nxt;
      r_decouple     <= w_decouple_nxt;
      r_paused       <= w_paused_nxt;
      r_busy         <= w_busy_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_ack_snapshot <= w_ack_snapshot_nxt;
    end
  end

  // Next state. In REQ/RELEASE the ack condition is tested before expiry so
  // acks completing in the expiry cycle win over the timeout.
  always_comb begin
    w_next        = r_state;
    w_timeout_evt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.pause_cmd) w_next = ST_REQ;
      end
      ST_REQ: begin
        if (w_ack_all) begin
          w_next = ST_DECOUPLE;
        end else if (w_expired) begin
          w_timeout_evt = 1'b1;
          w_next        = (FORCE_ON_TIMEOUT != 0) ? ST_DECOUPLE : ST_IDLE;
        end
      end
      ST_DECOUPLE: begin
        if (w_expired) w_next = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (bus.resume_cmd) w_next = ST_UNDECOUPLE;
      end
      ST_UNDECOUPLE: begin
        if (w_expired) w_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_ack_none) begin
          w_next = ST_IDLE;
        end else if (w_expired) begin
          w_timeout_evt = 1'b1;
          w_next        = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    w_stop_req_nxt     = '0;
    w_decouple_nxt     = 1'b0;
    w_paused_nxt       = 1'b0;
    w_busy_nxt         = 1'b0;
    w_load             = 1'b0;
    w_load_val         = SETTLE_LD;
    w_timeout_err_nxt  = r_timeout_err;
    w_ack_snapshot_nxt = r_ack_snapshot;

    case (w_next)
      ST_REQ:        begin w_stop_req_nxt = '1; w_busy_nxt = 1'b1; end
      ST_DECOUPLE:   begin w_stop_req_nxt = '1; w_decouple_nxt = 1'b1; w_busy_nxt = 1'b1; end
      ST_PAUSED:     begin w_stop_req_nxt = '1; w_decouple_nxt = 1'b1; w_paused_nxt = 1'b1; end
      ST_UNDECOUPLE: begin w_stop_req_nxt = '1; w_busy_nxt = 1'b1; end
      ST_RELEASE:    begin w_busy_nxt = 1'b1; end
      default:       begin end
    endcase

    // Each wait phase arms the timer only on entry; staying put never reloads.
    if ((w_next != r_state) && (w_next != ST_IDLE) && (w_next != ST_PAUSED)) begin
      w_load     = 1'b1;
      w_load_val = ((w_next == ST_REQ) || (w_next == ST_RELEASE)) ? TIMEOUT_LD : SETTLE_LD;
    end

    if ((r_state == ST_IDLE) && bus.pause_cmd) w_timeout_err_nxt = 1'b0;
    if (w_timeout_evt) begin
      w_timeout_err_nxt  = 1'b1;
      w_ack_snapshot_nxt = bus.stop_ack;
    end
  end

  assign bus.stop_req     = r_stop_req;
  assign bus.decouple     = r_decouple;
  assign bus.paused       = r_paused;
  assign bus.busy         = r_busy;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.ack_snapshot = r_ack_snapshot;

endmodule
